l1d_mem_req_sched: RTL and testbench

L1D_MEM_REQ_SCHED -- requirements
Module: l1d_mem_req_sched

---
 rtl/l1d_mem_req_sched_pkg.sv | 15 +
 rtl/l1d_mem_req_sched_arb.sv | 50 +++++
 rtl/l1d_mem_req_sched.sv | 105 ++++++++++
 tb/tb_l1d_mem_req_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/l1d_mem_req_sched_pkg.sv
// Shared L1D definitions for the memory request scheduler: FSM state encoding
// and the requester index width helper.
package rvh_l1d_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  // IDX_W for a given requester count; kept at least 1 bit wide.
  function automatic int unsigned calc_idx_w(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/l1d_mem_req_sched_arb.sv
// Round-robin arbiter: searches from the pointer upward with wrap, returns a
// one-hot grant plus its index; the pointer moves past upd_idx_i on update_i.
module one_hot_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req_i,
  input  logic             update_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic [N_REQ-1:0] grt_o,
  output logic [IDX_W-1:0] grt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grt_o     = '0;
    grt_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      idx = pos[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        grt_o[idx] = 1'b1;
        grt_idx_o  = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i)
      ptr_d = (upd_idx_i == IDX_W'(N_REQ-1)) ? '0 : upd_idx_i + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/l1d_mem_req_sched.sv
// Burst scheduler: grants the shared memory request port to one requester at a
// time for a whole burst, choosing round-robin among pending requesters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | port free; arbitrate among valid requesters, latch owner/len
// ST_BURST | owner streams beats until the beat with beat_cnt == 0 is taken
module l1d_mem_req_sched
  import rvh_l1d_pkg::*;
#(
  parameter  int          N_REQ  = 4,
  parameter  int          DATA_W = 64,
  parameter  int          LEN_W  = 3,
  localparam int unsigned IDX_W  = calc_idx_w(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ-1:0][LEN_W-1:0]   req_len_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          mem_valid_o,
  output logic [DATA_W-1:0]             mem_data_o,
  output logic [IDX_W-1:0]              mem_src_o,
  output logic                          mem_last_o,
  input  logic                          mem_ready_i,
  output logic                          busy_o
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] grt;
  logic [IDX_W-1:0] grt_idx;
  logic [LEN_W-1:0] len_sel;
  logic             hs, last_hs;

  one_hot_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (req_valid_i),
    .update_i  (last_hs),
    .upd_idx_i (owner_q),
    .grt_o     (grt),
    .grt_idx_o (grt_idx)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grt[i]) len_sel = len_sel | req_len_i[i];
  end

  assign hs      = (state_q == ST_BURST) && req_valid_i[owner_q] && mem_ready_i;
  assign last_hs = hs && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d = ST_BURST;
          owner_d = grt_idx;
          cnt_d   = len_sel;
        end
      end
      ST_BURST: begin
        if (last_hs)  state_d = ST_IDLE;
        else if (hs)  cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready depends only on registered ownership and mem_ready_i, never on valid.
  always_comb begin
    req_ready_o = '0;
    mem_valid_o = 1'b0;
    mem_last_o  = 1'b0;
    busy_o      = (state_q == ST_BURST);
    mem_src_o   = owner_q;
    mem_data_o  = req_data_i[owner_q];
    if (state_q == ST_BURST) begin
      mem_valid_o          = req_valid_i[owner_q];
      mem_last_o           = (cnt_q == '0);
      req_ready_o[owner_q] = mem_ready_i;
    end
  end

endmodule

// File: tb/tb_l1d_mem_req_sched.sv
// Self-checking bench for l1d_mem_req_sched: fixed vector table, directed
// corner sequences and a randomized run against a burst-level reference model.
module tb_l1d_mem_req_sched;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int LW = 3;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [N-1:0]          req_valid;
  logic [N-1:0][LW-1:0]  req_len;
  logic [N-1:0][DW-1:0]  req_data;
  logic [N-1:0]          req_ready;
  logic                  mem_valid;
  logic [DW-1:0]         mem_data;
  logic [1:0]            mem_src;
  logic                  mem_last;
  logic                  mem_ready;
  logic                  busy;

  always #5 clk = ~clk;

  l1d_mem_req_sched #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_len_i   (req_len),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .mem_valid_o (mem_valid),
    .mem_data_o  (mem_data),
    .mem_src_o   (mem_src),
    .mem_last_o  (mem_last),
    .mem_ready_i (mem_ready),
    .busy_o      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the port, beats still to move, next search start.
  bit m_busy;
  int m_owner, m_left, m_ptr;
  int gq[$];
  int hs_cnt;

  typedef struct {
    logic         rstn;
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] e_rdy;
    logic         e_val;
    logic [1:0]   e_src;
    logic         e_last;
    logic         e_busy;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic mr);
    logic [N-1:0] e_rdy;
    rstn = r; req_valid = v; mem_ready = mr;
    for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
    #4;
    e_rdy = (m_busy && mr) ? N'(1 << m_owner) : '0;
    chk("busy",      64'(busy),      64'(m_busy));
    chk("mem_valid", 64'(mem_valid), 64'(m_busy && v[m_owner]));
    chk("mem_last",  64'(mem_last),  64'(m_busy && m_left == 1));
    chk("mem_src",   64'(mem_src),   64'(m_owner));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    if (m_busy && v[m_owner]) chk("mem_data", mem_data, req_data[m_owner]);
    if (mem_valid && mr) hs_cnt++;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (v[idx]) begin
          m_owner = idx;
          m_left  = int'(req_len[idx]) + 1;
          m_busy  = 1;
          gq.push_back(idx);
          break;
        end
      end
    end else if (v[m_owner] && mr) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    rstn = 0; req_valid = '0; req_len = '0; req_data = '0; mem_ready = 0;
    hs_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // rstn, valid, ready | ready_o, valid_o, src, last, busy
    tbl[0]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
    req_len[0] = 3'd3;
    for (int t = 0; t < 14; t++) begin
      rstn = tbl[t].rstn; req_valid = tbl[t].valid; mem_ready = tbl[t].ready;
      for (int i = 0; i < N; i++) req_data[i] = {32'hD000_0000 + 32'(i), 32'(t)};
      #4;
      chk("tbl_ready", 64'(req_ready), 64'(tbl[t].e_rdy));
      chk("tbl_valid", 64'(mem_valid), 64'(tbl[t].e_val));
      chk("tbl_src",   64'(mem_src),   64'(tbl[t].e_src));
      chk("tbl_last",  64'(mem_last),  64'(tbl[t].e_last));
      chk("tbl_busy",  64'(busy),      64'(tbl[t].e_busy));
      if (tbl[t].e_val) chk("tbl_data", mem_data, {32'hD000_0000 + 32'(tbl[t].e_src), 32'(t)});
      @(posedge clk);
      #1;
    end

    rstn = 0; req_valid = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Fairness: everyone valid, single-beat bursts.
    req_len = '0; gq.delete();
    repeat (10) step(1'b1, 4'b1111, 1'b1);
    chk("fair_cnt", 64'(gq.size()), 64'd5);
    if (gq.size() >= 5) begin
      int fair_exp[5];
      fair_exp = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) chk("fair_order", 64'(gq[i]), 64'(fair_exp[i]));
    end

    // Backpressure on owner 2 with a two-beat burst.
    req_len[2] = 3'd1; hs_cnt = 0;
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    repeat (3) step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("bp_handshakes", 64'(hs_cnt), 64'd2);

    // Wrap-around from pointer 3.
    req_len = '0; gq.delete();
    repeat (4) step(1'b1, 4'b1001, 1'b1);
    chk("wrap_cnt", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) begin
      chk("wrap_first",  64'(gq[0]), 64'd3);
      chk("wrap_second", 64'(gq[1]), 64'd0);
    end

    // Owner drops valid while requester 1 waits.
    req_len[0] = 3'd3; req_len[1] = 3'd2; gq.delete();
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0001, 1'b1);
    repeat (2) step(1'b1, 4'b0010, 1'b1);
    repeat (3) step(1'b1, 4'b0011, 1'b1);
    step(1'b1, 4'b0010, 1'b1);
    chk("drop_cnt", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) begin
      chk("drop_owner", 64'(gq[0]), 64'd0);
      chk("drop_next",  64'(gq[1]), 64'd1);
    end
    repeat (3) step(1'b1, 4'b0010, 1'b1);
    step(1'b1, 4'b0000, 1'b1);

    // Reset at the second beat of an eight-beat burst.
    req_len = '0; req_len[2] = 3'd7;
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src",  64'(mem_src), 64'd0);
    req_len = '0; gq.delete();
    step(1'b1, 4'b1111, 1'b1);
    chk("rst_ptr_grant", 64'(gq.size() > 0 ? gq[0] : -1), 64'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) req_len[i] = LW'($urandom_range(0, 7));
      step(($urandom_range(0, 199) != 0), N'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
